// File: rtl/cpu_pkg.sv
// Shared constants and the next-PC source select used by the fetch front end.
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_PEND,
    SRC_BR,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_SEQ
  } next_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. push+pop together on a non-empty stack
// replaces the top entry; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf_evt,
  output logic         unf_evt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = wp_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign top     = mem_q[top_idx];
  assign ovf_evt = push && !pop && full;
  assign unf_evt = pop && empty;

  // Empty stack with push+pop degrades to a plain push
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push && pop && !empty) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-address select feeding the PC register: stall hold, pending branch,
// branch, return, call, jump and sequential, with a return-address stack.
module next_pc_unit #(
  parameter int unsigned PC_W      = cpu_pkg::PC_W,
  parameter int unsigned RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc_next,
  output logic            br_pend,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  import cpu_pkg::*;

  next_src_e       src_c;
  logic [PC_W-1:0] seq_c;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ras_push_c, ras_pop_c;
  logic [PC_W-1:0] ras_top;
  logic            ras_ovf_evt, ras_unf_evt;

  assign seq_c = pc_cur + PC_W'(1);

  // A pending branch yields to a fresh taken branch in the same cycle
  always_comb begin
    src_c = SRC_SEQ;
    if (stall)                    src_c = SRC_HOLD;
    else if (pend_q && !br_taken) src_c = SRC_PEND;
    else if (br_taken)            src_c = SRC_BR;
    else if (ret)                 src_c = SRC_RET;
    else if (call)                src_c = SRC_CALL;
    else if (jmp)                 src_c = SRC_JMP;
  end

  always_comb begin
    pc_next = seq_c;
    case (src_c)
      SRC_HOLD: pc_next = pc_cur;
      SRC_PEND: pc_next = pend_tgt_q;
      SRC_BR:   pc_next = br_target;
      SRC_RET:  pc_next = ras_empty ? seq_c : ras_top;
      SRC_CALL: pc_next = jmp_target;
      SRC_JMP:  pc_next = jmp_target;
      default:  pc_next = seq_c;
    endcase
    if (!reset) pc_next = '0;
  end

  // call+ret becomes push+pop, which the stack treats as replace-top
  assign ras_push_c = (src_c == SRC_CALL) || ((src_c == SRC_RET) && call);
  assign ras_pop_c  = (src_c == SRC_RET);

  always_comb begin
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (stall) begin
      if (br_taken) begin
        pend_d     = 1'b1;
        pend_tgt_d = br_target;
      end
    end else begin
      pend_d = 1'b0;
    end
    ovf_d = ovf_q | ras_ovf_evt;
    unf_d = unf_q | ras_unf_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_c),
    .pop       (ras_pop_c),
    .push_data (seq_c),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf_evt   (ras_ovf_evt),
    .unf_evt   (ras_unf_evt)
  );

  assign br_pend = pend_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit.
module tb_next_pc_unit;

  logic       clk;
  logic       reset;
  logic [9:0] pc_cur;
  logic       stall;
  logic       br_taken;
  logic [9:0] br_target;
  logic       jmp;
  logic [9:0] jmp_target;
  logic       call;
  logic       ret;
  logic [9:0] pc_next;
  logic       br_pend;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_ovf;
  logic       ras_unf;

  int checks = 0;
  int errors = 0;

  next_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_cur     (pc_cur),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .pc_next    (pc_next),
    .br_pend    (br_pend),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the combinational pc_next, then take the edge
  task automatic cyc(input string tag, input logic [9:0] pc, input logic st,
                     input logic bt, input logic [9:0] btg, input logic j,
                     input logic c, input logic r, input logic [9:0] jt,
                     input logic [9:0] exp);
    pc_cur     = pc;
    stall      = st;
    br_taken   = bt;
    br_target  = btg;
    jmp        = j;
    call       = c;
    ret        = r;
    jmp_target = jt;
    #1;
    check(tag, 32'(pc_next), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] pc_m;
    reset      = 1'b0;
    pc_cur     = 10'd77;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    jmp        = 1'b0;
    jmp_target = '0;
    call       = 1'b0;
    ret        = 1'b0;
    #3;
    check("rst_pc_next", 32'(pc_next), 32'd0);
    check("rst_br_pend", 32'(br_pend), 32'd0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_full", 32'(ras_full), 32'd0);
    check("rst_ovf", 32'(ras_ovf), 32'd0);
    check("rst_unf", 32'(ras_unf), 32'd0);
    @(posedge clk);
    #2;
    check("rst_pc_next_edge", 32'(pc_next), 32'd0);
    reset = 1'b1;

    // PC register model: pc_cur takes the previous expected pc_next
    pc_m = 10'd0;
    for (int i = 1; i <= 3; i++) begin
      cyc("seq", pc_m, 0, 0, 0, 0, 0, 0, 0, 10'(i));
      pc_m = 10'(i);
    end
    cyc("seq_wrap", 10'd1023, 0, 0, 0, 0, 0, 0, 0, 10'd0);

    // Stall with branch arriving mid-stall; call during stall is ignored
    cyc("stall1", 10'd5, 1, 0, 0, 0, 0, 0, 0, 10'd5);
    cyc("stall2", 10'd5, 1, 1, 10'd200, 0, 0, 0, 0, 10'd5);
    check("pend_set", 32'(br_pend), 32'd1);
    cyc("stall3", 10'd5, 1, 0, 0, 0, 1, 0, 10'd90, 10'd5);
    check("pend_hold", 32'(br_pend), 32'd1);
    check("stall_call_ignored", 32'(ras_empty), 32'd1);
    cyc("pend_redirect", 10'd5, 0, 0, 0, 0, 0, 0, 0, 10'd200);
    check("pend_clear", 32'(br_pend), 32'd0);

    cyc("br_beats_call", 10'd7, 0, 1, 10'd40, 0, 1, 0, 10'd90, 10'd40);
    check("br_call_empty", 32'(ras_empty), 32'd1);

    cyc("jmp", 10'd30, 0, 0, 0, 1, 0, 0, 10'd123, 10'd123);

    cyc("call", 10'd10, 0, 0, 0, 0, 1, 0, 10'd100, 10'd100);
    check("call_nonempty", 32'(ras_empty), 32'd0);
    cyc("ret", 10'd150, 0, 0, 0, 0, 0, 1, 0, 10'd11);
    check("ret_empty", 32'(ras_empty), 32'd1);

    // Five calls into a 4-deep stack: return addresses 2..6, oldest lost
    for (int i = 1; i <= 5; i++)
      cyc("ovf_call", 10'(i), 0, 0, 0, 0, 1, 0, 10'd500, 10'd500);
    check("ovf_flag", 32'(ras_ovf), 32'd1);
    check("ovf_full", 32'(ras_full), 32'd1);
    for (int i = 0; i < 4; i++)
      cyc("ovf_ret", 10'd700, 0, 0, 0, 0, 0, 1, 0, 10'(6 - i));
    check("ovf_drained", 32'(ras_empty), 32'd1);
    check("ovf_not_full", 32'(ras_full), 32'd0);
    check("no_unf_yet", 32'(ras_unf), 32'd0);

    cyc("unf_ret", 10'd20, 0, 0, 0, 0, 0, 1, 0, 10'd21);
    check("unf_flag", 32'(ras_unf), 32'd1);
    cyc("push51", 10'd50, 0, 0, 0, 0, 1, 0, 10'd300, 10'd300);
    cyc("call_ret", 10'd60, 0, 0, 0, 0, 1, 1, 10'd300, 10'd51);
    check("call_ret_count", 32'(ras_empty), 32'd0);
    check("call_ret_notfull", 32'(ras_full), 32'd0);
    cyc("ret_61", 10'd80, 0, 0, 0, 0, 0, 1, 0, 10'd61);
    check("ret_61_empty", 32'(ras_empty), 32'd1);
    check("ovf_sticky", 32'(ras_ovf), 32'd1);
    check("unf_sticky", 32'(ras_unf), 32'd1);

    // Async reset while a branch is pending
    cyc("rst_stall", 10'd9, 1, 1, 10'd400, 0, 0, 0, 0, 10'd9);
    check("rst_stall_pend", 32'(br_pend), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_pend", 32'(br_pend), 32'd0);
    check("midrst_pc_next", 32'(pc_next), 32'd0);
    check("midrst_ovf", 32'(ras_ovf), 32'd0);
    check("midrst_unf", 32'(ras_unf), 32'd0);
    #1;
    reset = 1'b1;
    cyc("post_rst", 10'd9, 0, 0, 0, 0, 0, 0, 0, 10'd10);
    check("post_rst_pend", 32'(br_pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
